uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART byte transmitter (19200 baud, 100 MHz) among NUM_REQ byte requesters.
//  Selects a requester by round-robin, accepts one byte, pulses the transmitter start and
//  tracks the transmitter busy flag until the frame completes, then enforces an idle gap.
//  Sits between the status/echo producers and the TX serializer, alongside the RX path.
// PARAMETERS
//  NUM_REQ      4      number of requesters (2..8)
//  ID_W         2      width of grant_id; must equal clog2(NUM_REQ)
//  GAP_CLKS     5208   idle clocks after tx_busy falls before next grant (1 bit time)
//  ACK_TIMEOUT  16     max clocks waiting for tx_busy to rise after tx_start
// PORTS
//  CLK          in   1            system clock, 100 MHz
//  RESET        in   1            synchronous, active-high reset
//  req_valid    in   NUM_REQ      requester i has a byte on req_data[8i+7:8i]
//  req_data     in   8*NUM_REQ    packed byte per requester
//  req_last     in   NUM_REQ      byte is the final byte of a packet (used only with lock feature)
//  req_ready    out  NUM_REQ      one-hot accept strobe; byte transferred when valid&ready
//  tx_data      out  8            byte to the serializer; held stable from START until next accept
//  tx_start     out  1            one-clock start pulse to the serializer
//  tx_busy      in   1            serializer frame in progress
//  grant_id     out  ID_W         index of the requester whose byte is in flight
//  tx_err       out  1            one-clock pulse: tx_busy did not rise within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, tx_err=0,
//   rr_ptr=NUM_REQ-1 (requester 0 has top priority first), gap counter=0, lock cleared.
//  Reset mid-operation aborts everything in one cycle; a byte in flight is dropped silently.
//  FSM states: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> GAP -> IDLE.
//  IDLE: if any eligible req_valid, winner w = first valid at index rr_ptr+1, rr_ptr+2, ...
//   (mod NUM_REQ). req_ready[w]=1 combinationally in this cycle only; req_data[w] captured
//   into tx_data, grant_id<=w, rr_ptr<=w; next state START. No valid: stay, all ready=0.
//  START: tx_start=1 for exactly this cycle; next WAIT_BUSY with timeout counter cleared.
//  WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Counter reaches ACK_TIMEOUT with tx_busy=0 ->
//   tx_err=1 for one cycle, go GAP (byte lost, no retry).
//  WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> GAP, counter cleared.
//  GAP: count GAP_CLKS cycles, then IDLE. GAP_CLKS=0 -> straight to IDLE next cycle.
//  Latency: accept at cycle N, tx_start at N+1; earliest next accept at
//   (busy-fall cycle)+GAP_CLKS+1. Max one byte in flight; no buffering.
//  req_ready never asserted outside IDLE; never more than one bit set.
//  Requester dropping req_valid before grant: legal, simply not selected.
//  tx_busy already high in IDLE: ignored; tx_busy high in GAP: ignored.
//  Counters: 16-bit, saturate-free since bounded by parameters; compare with ==.
// CONFIGURATION
//  UART_TX_ARB_PKT_LOCK_EN defined: after accepting a byte with req_last=0 from w, lock=1 and
//   only requester w is eligible in IDLE (others see ready=0) until a byte with req_last=1
//   from w is accepted; tx_err also clears lock. Prevents interleaving of multi-byte messages.
//  Not defined: req_last ignored, every byte is arbitrated independently (pure round-robin).
// STRUCTURE
//  Package uart_pkg: state encoding constants (IDLE..GAP), CLOCKS_PER_BIT=5208 used as
//   GAP_CLKS default, shared with RX/TX blocks.
//  Sub-module rr_pick: combinational round-robin picker (req vector, rr_ptr, mask) -> winner
//   index + any-valid flag; reusable by other arbiters.
// TESTING
//  Reset then req_valid=4'b0001, data0=8'h41 -> ready[0] one cycle, tx_start next cycle, tx_data=8'h41, grant_id=0.
//  All four valid continuously, model busy 100 clks -> grant order 0,1,2,3,0; no ready during busy/gap.
//  After busy falls with GAP_CLKS=5208 -> next req_ready exactly 5209 clocks later.
//  tx_busy held 0 after tx_start -> tx_err pulse 16 clocks after WAIT_BUSY entry, next grant after gap.
//  LOCK_EN: req1 sends 3 bytes (last on 3rd) with req0 valid -> bytes 1,1,1 then 0; without macro 1,0,1,0.
//  RESET asserted in WAIT_DONE -> next cycle outputs at reset values, req0 wins first afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX arbiter state encoding and bit timing (100 MHz, 19200 baud).
package uart_pkg;

   localparam int CLOCKS_PER_BIT = 5208;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;

   typedef logic [15:0] cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible request after rr_ptr, wrapping modulo N.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    mask,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [ID_W-1:0] winner,
   output logic            any
);

   logic [N-1:0]   elig;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             base;

   // Rotate the doubled vector so bit 0 is the requester just after rr_ptr.
   always_comb begin
      elig   = req & mask;
      dbl    = {elig, elig};
      base   = int'(rr_ptr) + 1;
      rot    = N'(dbl >> base);
      winner = '0;
      any    = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            any    = 1'b1;
            winner = ID_W'((base + i) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters.
// Optional packet lock (no interleaving of multi-byte messages): define UART_TX_ARB_PKT_LOCK_EN.
//
// state        | meaning
// ST_IDLE      | waiting for an eligible requester, accept strobe is combinational
// ST_START     | one-clock tx_start pulse to the serializer
// ST_WAIT_BUSY | waiting for tx_busy to rise, bounded by ACK_TIMEOUT
// ST_WAIT_DONE | frame in progress, waiting for tx_busy to fall
// ST_GAP       | idle gap of GAP_CLKS clocks before the next grant
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int GAP_CLKS    = CLOCKS_PER_BIT,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 tx_err
);

   localparam cnt_t ACK_LAST = cnt_t'(ACK_TIMEOUT);
   localparam cnt_t GAP_LAST = cnt_t'(GAP_CLKS - 1);

   logic [2:0]         state_q, state_d;
   cnt_t               cnt_q, cnt_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] mask;
   logic [ID_W-1:0]    pick_w;
   logic               pick_any;
   logic               accept;

   rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req    (req_valid),
      .mask   (mask),
      .rr_ptr (rr_ptr_q),
      .winner (pick_w),
      .any    (pick_any)
   );

`ifdef UART_TX_ARB_PKT_LOCK_EN
   // While locked only the previous winner (still held in rr_ptr) is eligible.
   logic lock_q, lock_d;

   always_comb begin
      mask = '1;
      if (lock_q) begin
         mask           = '0;
         mask[rr_ptr_q] = 1'b1;
      end
   end

   always_comb begin
      lock_d = lock_q;
      if (accept) begin
         lock_d = ~req_last[pick_w];
      end else if (tx_err) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   logic unused_last;

   assign mask        = '1;
   assign unused_last = ^req_last;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      req_ready  = '0;
      tx_start   = 1'b0;
      tx_err     = 1'b0;
      accept     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by RESET so no byte is handed over while the FSM is being cleared.
            if (pick_any && !RESET) begin
               accept            = 1'b1;
               req_ready[pick_w] = 1'b1;
               tx_data_d         = req_data[{pick_w, 3'b000} +: 8];
               grant_id_d        = pick_w;
               rr_ptr_d          = pick_w;
               state_d           = ST_START;
            end
         end
         ST_START: begin
            tx_start = 1'b1;
            cnt_d    = '0;
            state_d  = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == ACK_LAST) begin
               tx_err  = 1'b1;
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (GAP_CLKS == 0 || cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= ID_W'(NUM_REQ - 1);
         tx_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign grant_id = grant_id_q;

endmodule
